// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 modified-Booth multiplier, two multiplier bits retired per clock.
// Operands and product move through independent valid/ready handshakes; signed/unsigned per transaction.
module booth_radix4_seq_mult #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_signed,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int unsigned W    = (N % 2 == 0) ? N + 2 : N + 3;
  localparam int unsigned AW   = W + 2;
  localparam int unsigned ITER = W / 2;
  localparam int unsigned CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  a_q, a_d;
  logic [W-1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [W-1:0]   m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic [AW-1:0]  m_wide;
  logic [AW-1:0]  addend;
  logic [AW-1:0]  sum;
  logic [AW-1:0]  a_next;
  logic [W-1:0]   q_next;

  // One Booth step: digit select, accumulate at W+2 bits, arithmetic shift right by two.
  always_comb begin
    m_wide = {{2{m_q[W-1]}}, m_q};
    addend = '0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_wide;
      3'b011:         addend = m_wide << 1;
      3'b100:         addend = AW'(0) - (m_wide << 1);
      3'b101, 3'b110: addend = AW'(0) - m_wide;
      default:        addend = '0;
    endcase
    sum    = a_q + addend;
    a_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_next = {sum[1:0], q_q[W-1:2]};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    qm1_d       = qm1_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          m_d        = in_signed ? {{(W-N){multiplicand[N-1]}}, multiplicand}
                                 : {{(W-N){1'b0}}, multiplicand};
          q_d        = in_signed ? {{(W-N){multiplier[N-1]}}, multiplier}
                                 : {{(W-N){1'b0}}, multiplier};
          qm1_d      = 1'b0;
          a_d        = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CALC;
        end
      end
      CALC: begin
        a_d   = a_next;
        q_d   = q_next;
        qm1_d = q_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          product_d   = (2*N)'({a_next, q_next});
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Reset wins over any handshake, discarding an in-flight multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      m_q         <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      qm1_q       <= qm1_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Directed bench for booth_radix4_seq_mult at N=5, 8 and 16: products, latency,
// backpressure, overlap rejection and mid-operation reset.
module tb_booth_radix4_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv, isg, ordy;
  logic [15:0] mc [3];
  logic [15:0] mp [3];

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [9:0]  p0;
  logic [15:0] p1;
  logic [31:0] p2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  booth_radix4_seq_mult #(.N(5)) u_mul5 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy0), .in_signed(isg[0]),
    .multiplicand(mc[0][4:0]), .multiplier(mp[0][4:0]), .out_valid(ov0),
    .out_ready(ordy[0]), .product(p0), .busy(bz0)
  );

  booth_radix4_seq_mult #(.N(8)) u_mul8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy1), .in_signed(isg[1]),
    .multiplicand(mc[1][7:0]), .multiplier(mp[1][7:0]), .out_valid(ov1),
    .out_ready(ordy[1]), .product(p1), .busy(bz1)
  );

  booth_radix4_seq_mult #(.N(16)) u_mul16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy2), .in_signed(isg[2]),
    .multiplicand(mc[2]), .multiplier(mp[2]), .out_valid(ov2),
    .out_ready(ordy[2]), .product(p2), .busy(bz2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic f_rdy(input int sel);
    case (sel)
      0: return rdy0;
      1: return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic f_ov(input int sel);
    case (sel)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic f_bz(input int sel);
    case (sel)
      0: return bz0;
      1: return bz1;
      default: return bz2;
    endcase
  endfunction

  function automatic logic [31:0] f_prod(input int sel);
    case (sel)
      0: return {22'b0, p0};
      1: return {16'b0, p1};
      default: return p2;
    endcase
  endfunction

  function automatic int bits_of(input int sel);
    case (sel)
      0: return 5;
      1: return 8;
      default: return 16;
    endcase
  endfunction

  // Expected accept-to-valid edge count: ITER+1 with ITER = ceil_even(N+2)/2.
  function automatic int lat_of(input int sel);
    case (sel)
      0: return 5;
      1: return 6;
      default: return 10;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input int n, input logic sg,
                                          input logic [15:0] a, input logic [15:0] b);
    longint ua, ub, msk, r;
    msk = (longint'(1) << n) - 1;
    ua  = longint'(a) & msk;
    ub  = longint'(b) & msk;
    if (sg && ua[n-1]) ua = ua - (longint'(1) << n);
    if (sg && ub[n-1]) ub = ub - (longint'(1) << n);
    r = ua * ub;
    return 32'(r & ((longint'(1) << (2 * n)) - 1));
  endfunction

  function automatic logic [15:0] corner(input int n, input int idx);
    logic [15:0] one;
    one = 16'd1;
    case (idx)
      0: return 16'd0;
      1: return 16'd1;
      2: return 16'((one << n) - 16'd1);
      3: return 16'(one << (n - 1));
      default: return 16'((one << (n - 1)) - 16'd1);
    endcase
  endfunction

  // One full transaction; hold = DONE cycles under backpressure, poke = in_valid pulses in CALC/DONE.
  task automatic do_mul(input int sel, input logic sg, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input logic poke, output logic [31:0] p, output int lat);
    int guard;
    logic [31:0] held;
    guard = 0;
    lat   = 0;
    while (!f_rdy(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(f_rdy(sel)), 32'd1);
    isg[sel] = sg;
    mc[sel]  = a;
    mp[sel]  = b;
    iv[sel]  = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv[sel]  = 1'b0;
    isg[sel] = ~sg;
    mc[sel]  = ~a;
    mp[sel]  = a ^ b ^ 16'h5a5a;
    check("busy_calc", 32'(f_bz(sel)), 32'd1);
    check("in_ready_calc", 32'(f_rdy(sel)), 32'd0);
    while (!f_ov(sel) && lat < 100) begin
      iv[sel] = poke && (lat == 2);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    iv[sel] = 1'b0;
    check("out_valid_seen", 32'(f_ov(sel)), 32'd1);
    p    = f_prod(sel);
    held = p;
    for (int i = 0; i < hold; i++) begin
      iv[sel] = poke && (i == 1);
      @(posedge clk);
      @(negedge clk);
      check("hold_product", f_prod(sel), held);
      check("hold_out_valid", 32'(f_ov(sel)), 32'd1);
      check("hold_in_ready", 32'(f_rdy(sel)), 32'd0);
      check("hold_busy", 32'(f_bz(sel)), 32'd1);
    end
    iv[sel]   = 1'b0;
    ordy[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[sel] = 1'b0;
    check("drain_out_valid", 32'(f_ov(sel)), 32'd0);
    check("drain_in_ready", 32'(f_rdy(sel)), 32'd1);
    check("drain_busy", 32'(f_bz(sel)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    int          lat;
    int          seen;
    logic [15:0] ra, rb;

    rst  = 1'b1;
    iv   = '0;
    isg  = '0;
    ordy = '0;
    for (int s = 0; s < 3; s++) begin
      mc[s] = '0;
      mp[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_in_ready_%0d", s), 32'(f_rdy(s)), 32'd1);
      check($sformatf("reset_out_valid_%0d", s), 32'(f_ov(s)), 32'd0);
      check($sformatf("reset_busy_%0d", s), 32'(f_bz(s)), 32'd0);
      check($sformatf("reset_product_%0d", s), f_prod(s), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // N=8 directed signed and unsigned vectors.
    do_mul(1, 1'b1, 16'h00FD, 16'h0005, 0, 1'b0, p, lat);
    check("s8_m3x5", p, 32'h0000_FFF1);
    check("s8_m3x5_lat", 32'(lat), 32'd6);
    do_mul(1, 1'b1, 16'h0080, 16'h0080, 0, 1'b0, p, lat);
    check("s8_min_x_min", p, 32'h0000_4000);
    check("s8_min_x_min_lat", 32'(lat), 32'd6);
    do_mul(1, 1'b1, 16'h007F, 16'h0080, 0, 1'b0, p, lat);
    check("s8_max_x_min", p, 32'h0000_C080);
    check("s8_max_x_min_lat", 32'(lat), 32'd6);
    do_mul(1, 1'b0, 16'h00FF, 16'h00FF, 0, 1'b0, p, lat);
    check("u8_255x255", p, 32'h0000_FE01);
    do_mul(1, 1'b0, 16'h0080, 16'h0002, 0, 1'b0, p, lat);
    check("u8_128x2", p, 32'h0000_0100);
    do_mul(1, 1'b0, 16'h0000, 16'h00C8, 0, 1'b0, p, lat);
    check("u8_0x200", p, 32'h0000_0000);
    do_mul(1, 1'b1, 16'h00FF, 16'h00FF, 0, 1'b0, p, lat);
    check("s8_m1xm1", p, 32'h0000_0001);

    // Backpressure for 20 cycles.
    do_mul(1, 1'b1, 16'h00FD, 16'h0005, 20, 1'b0, p, lat);
    check("bp_product", p, 32'h0000_FFF1);

    // in_valid pulses during CALC and DONE must not start a second multiply.
    do_mul(1, 1'b0, 16'h000C, 16'h000B, 4, 1'b1, p, lat);
    check("overlap_product", p, 32'h0000_0084);
    @(negedge clk);
    check("overlap_no_accept", 32'(bz1), 32'd0);
    do_mul(1, 1'b1, 16'h00F6, 16'h0011, 0, 1'b0, p, lat);
    check("after_overlap", p, 32'h0000_FF56);

    // Reset on the third CALC edge aborts the multiply.
    isg[1] = 1'b0;
    mc[1]  = 16'h000B;
    mp[1]  = 16'h000D;
    iv[1]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(rdy1), 32'd1);
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_busy", 32'(bz1), 32'd0);
    check("rst_product", 32'(p1), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov1) seen++;
    end
    check("rst_no_emit", 32'(seen), 32'd0);
    do_mul(1, 1'b0, 16'h0007, 16'h0009, 0, 1'b0, p, lat);
    check("rst_then_7x9", p, 32'd63);

    // N=5 and N=16: corner pairs and random operands against the reference model.
    for (int s = 0; s < 3; s += 2) begin
      for (int sg = 0; sg < 2; sg++) begin
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 5; j++) begin
            ra = corner(bits_of(s), i);
            rb = corner(bits_of(s), j);
            do_mul(s, 1'(sg), ra, rb, 0, 1'b0, p, lat);
            check($sformatf("sweep_n%0d_s%0d_%0h_%0h", bits_of(s), sg, ra, rb),
                  p, ref_mul(bits_of(s), 1'(sg), ra, rb));
            check($sformatf("sweep_lat_n%0d", bits_of(s)), 32'(lat), 32'(lat_of(s)));
          end
        end
        for (int k = 0; k < 10; k++) begin
          ra = 16'($urandom) & corner(bits_of(s), 2);
          rb = 16'($urandom) & corner(bits_of(s), 2);
          do_mul(s, 1'(sg), ra, rb, 0, 1'b0, p, lat);
          check($sformatf("rand_n%0d_s%0d_%0h_%0h", bits_of(s), sg, ra, rb),
                p, ref_mul(bits_of(s), 1'(sg), ra, rb));
          check($sformatf("rand_lat_n%0d", bits_of(s)), 32'(lat), 32'(lat_of(s)));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
